execution_buffer: RTL and testbench

EXECUTION_BUFFER -- requirements
Module: execution_buffer

---
 rtl/execution_buffer_pkg.sv | 46 ++++
 rtl/d_reg_busy_table.sv | 37 +++
 rtl/execution_buffer.sv | 162 ++++++++++++++++
 tb/tb_execution_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/execution_buffer_pkg.sv
// Shared types for the issue stage: ALU opcodes, register-file sizes and the
// execution-buffer entry layout.
package execution_buffer_pkg;

  localparam int unsigned NumDReg       = 32;
  localparam int unsigned NumSReg       = 8;
  localparam int unsigned RobSize       = 16;
  localparam int unsigned EbSizeDefault = 8;

  localparam int unsigned DRegW = $clog2(NumDReg);
  localparam int unsigned SRegW = $clog2(NumSReg);
  localparam int unsigned RobW  = $clog2(RobSize);

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluNand,
    AluShl,
    AluShr
  } alu_op_t;

  typedef struct packed {
    logic [RobW-1:0]  rob_addr;
    alu_op_t          alu_op;
    logic [15:0]      immdt;
    logic [DRegW-1:0] ra_addr;
    logic             use_rt;
    logic [DRegW-1:0] rt_addr;
    logic             write_dst;
    logic [DRegW-1:0] rw_addr;
    logic [DRegW-1:0] prev_rw_addr;
    logic [SRegW-1:0] rs_addr;
    logic [SRegW-1:0] prev_rs_addr;
  } eb_payload_t;

  typedef struct packed {
    eb_payload_t p;
    logic        ra_rdy;
    logic        rt_rdy;
    logic        valid;
  } eb_entry_t;

endpackage

// File: rtl/d_reg_busy_table.sv
// One busy bit per physical D-register; lookups see a same-cycle writeback.
module d_reg_busy_table
  import execution_buffer_pkg::*;
#(
  parameter int unsigned NumRegs = NumDReg,
  parameter int unsigned AW      = $clog2(NumRegs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_valid,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] lookup_a_addr,
  output logic          lookup_a_rdy,
  input  logic [AW-1:0] lookup_b_addr,
  output logic          lookup_b_rdy
);

  logic [NumRegs-1:0] busy_q, busy_d;

  // Set is applied after clear so a new producer wins over a stale writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    if (set_valid) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign lookup_a_rdy = !busy_q[lookup_a_addr] || (clr_valid && clr_addr == lookup_a_addr);
  assign lookup_b_rdy = !busy_q[lookup_b_addr] || (clr_valid && clr_addr == lookup_b_addr);

endmodule

// File: rtl/execution_buffer.sv
// Collapsing issue queue: oldest-first selection of ready instructions,
// wakeup on D-register writeback, flush on mispredict.
module execution_buffer
  import execution_buffer_pkg::*;
#(
  parameter int unsigned EB_SIZE = EbSizeDefault,
  parameter int unsigned D_W     = DRegW,
  parameter int unsigned S_W     = SRegW,
  parameter int unsigned R_W     = RobW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [R_W-1:0] in_rob_addr,
  input  alu_op_t        in_alu_op,
  input  logic [15:0]    in_immdt,
  input  logic [D_W-1:0] in_ra_addr,
  input  logic           in_use_rt,
  input  logic [D_W-1:0] in_rt_addr,
  input  logic           in_write_dst,
  input  logic [D_W-1:0] in_rw_addr,
  input  logic [D_W-1:0] in_prev_rw_addr,
  input  logic [S_W-1:0] in_rs_addr,
  input  logic [S_W-1:0] in_prev_rs_addr,
  output logic           full,
  input  logic           wb_valid,
  input  logic [D_W-1:0] wb_rw_addr,
  input  logic           ex_stall,
  input  logic           flush,
  output logic           out_valid,
  output logic [R_W-1:0] out_rob_addr,
  output alu_op_t        out_alu_op,
  output logic [15:0]    out_immdt,
  output logic [D_W-1:0] out_ra_addr,
  output logic           out_use_rt,
  output logic [D_W-1:0] out_rt_addr,
  output logic           out_write_dst,
  output logic [D_W-1:0] out_rw_addr,
  output logic [D_W-1:0] out_prev_rw_addr,
  output logic [S_W-1:0] out_rs_addr,
  output logic [S_W-1:0] out_prev_rs_addr
);

  localparam int unsigned IW = $clog2(EB_SIZE);
  localparam int unsigned CW = IW + 1;

  eb_entry_t          entries_q [EB_SIZE];
  eb_entry_t          entries_d [EB_SIZE];
  eb_entry_t          woken     [EB_SIZE+1];
  eb_entry_t          new_entry;
  logic [CW-1:0]      count_q, count_d, wr_idx;
  logic [EB_SIZE-1:0] eligible;
  logic [IW-1:0]      sel_idx;
  logic               any_elig, issue, accept;
  logic               ra_rdy, rt_rdy;

  assign full      = (count_q == CW'(EB_SIZE));
  assign accept    = in_valid && !full && !flush;
  assign out_valid = any_elig && !ex_stall && !flush;
  assign issue     = out_valid;

  d_reg_busy_table #(
    .NumRegs(1 << D_W),
    .AW     (D_W)
  ) u_busy (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (accept && in_write_dst),
    .set_addr     (in_rw_addr),
    .clr_valid    (wb_valid),
    .clr_addr     (wb_rw_addr),
    .lookup_a_addr(in_ra_addr),
    .lookup_a_rdy (ra_rdy),
    .lookup_b_addr(in_rt_addr),
    .lookup_b_rdy (rt_rdy)
  );

  // Descending scan leaves the lowest eligible index; defaults to entry 0.
  always_comb begin
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = EB_SIZE - 1; i >= 0; i--) begin
      eligible[i] = entries_q[i].valid && entries_q[i].ra_rdy && entries_q[i].rt_rdy;
      if (eligible[i]) begin
        sel_idx  = IW'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    new_entry                = '0;
    new_entry.p.rob_addr     = in_rob_addr;
    new_entry.p.alu_op       = in_alu_op;
    new_entry.p.immdt        = in_immdt;
    new_entry.p.ra_addr      = in_ra_addr;
    new_entry.p.use_rt       = in_use_rt;
    new_entry.p.rt_addr      = in_rt_addr;
    new_entry.p.write_dst    = in_write_dst;
    new_entry.p.rw_addr      = in_rw_addr;
    new_entry.p.prev_rw_addr = in_prev_rw_addr;
    new_entry.p.rs_addr      = in_rs_addr;
    new_entry.p.prev_rs_addr = in_prev_rs_addr;
    new_entry.ra_rdy         = ra_rdy;
    new_entry.rt_rdy         = !in_use_rt || rt_rdy;
    new_entry.valid          = 1'b1;

    woken[EB_SIZE] = '0;
    for (int i = 0; i < EB_SIZE; i++) begin
      woken[i] = entries_q[i];
      if (wb_valid && entries_q[i].valid) begin
        if (entries_q[i].p.ra_addr == wb_rw_addr) woken[i].ra_rdy = 1'b1;
        if (entries_q[i].p.rt_addr == wb_rw_addr) woken[i].rt_rdy = 1'b1;
      end
    end

    // Entries at and above the issued slot move down one place.
    for (int i = 0; i < EB_SIZE; i++) begin
      if (issue && i >= int'(sel_idx)) entries_d[i] = woken[i+1];
      else                             entries_d[i] = woken[i];
    end

    wr_idx = count_q - CW'(issue);
    if (accept) begin
      for (int i = 0; i < EB_SIZE; i++) begin
        if (CW'(i) == wr_idx) entries_d[i] = new_entry;
      end
    end

    if (flush) begin
      for (int i = 0; i < EB_SIZE; i++) entries_d[i].valid = 1'b0;
      count_d = '0;
    end else begin
      count_d = count_q + CW'(accept) - CW'(issue);
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < EB_SIZE; i++) entries_q[i].valid <= 1'b0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    out_rob_addr     = entries_q[sel_idx].p.rob_addr;
    out_alu_op       = entries_q[sel_idx].p.alu_op;
    out_immdt        = entries_q[sel_idx].p.immdt;
    out_ra_addr      = entries_q[sel_idx].p.ra_addr;
    out_use_rt       = entries_q[sel_idx].p.use_rt;
    out_rt_addr      = entries_q[sel_idx].p.rt_addr;
    out_write_dst    = entries_q[sel_idx].p.write_dst;
    out_rw_addr      = entries_q[sel_idx].p.rw_addr;
    out_prev_rw_addr = entries_q[sel_idx].p.prev_rw_addr;
    out_rs_addr      = entries_q[sel_idx].p.rs_addr;
    out_prev_rs_addr = entries_q[sel_idx].p.prev_rs_addr;
  end

endmodule

// File: tb/tb_execution_buffer.sv
// Randomised bench for execution_buffer with a queue-level reference model and
// a scoreboard checked at the falling clock edge.
module tb_execution_buffer;
  import execution_buffer_pkg::*;

  localparam int unsigned EB = EbSizeDefault;
  localparam int unsigned DW = DRegW;
  localparam int unsigned SW = SRegW;
  localparam int unsigned RW = RobW;

  logic          clk, rst;
  logic          in_valid, in_use_rt, in_write_dst;
  logic [RW-1:0] in_rob_addr;
  alu_op_t       in_alu_op;
  logic [15:0]   in_immdt;
  logic [DW-1:0] in_ra_addr, in_rt_addr, in_rw_addr, in_prev_rw_addr;
  logic [SW-1:0] in_rs_addr, in_prev_rs_addr;
  logic          full, wb_valid, ex_stall, flush, out_valid;
  logic [DW-1:0] wb_rw_addr;
  logic [RW-1:0] out_rob_addr;
  alu_op_t       out_alu_op;
  logic [15:0]   out_immdt;
  logic [DW-1:0] out_ra_addr, out_rt_addr, out_rw_addr, out_prev_rw_addr;
  logic          out_use_rt, out_write_dst;
  logic [SW-1:0] out_rs_addr, out_prev_rs_addr;

  execution_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rob_addr(in_rob_addr),
    .in_alu_op(in_alu_op), .in_immdt(in_immdt), .in_ra_addr(in_ra_addr),
    .in_use_rt(in_use_rt), .in_rt_addr(in_rt_addr), .in_write_dst(in_write_dst),
    .in_rw_addr(in_rw_addr), .in_prev_rw_addr(in_prev_rw_addr), .in_rs_addr(in_rs_addr),
    .in_prev_rs_addr(in_prev_rs_addr), .full(full), .wb_valid(wb_valid),
    .wb_rw_addr(wb_rw_addr), .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid),
    .out_rob_addr(out_rob_addr), .out_alu_op(out_alu_op), .out_immdt(out_immdt),
    .out_ra_addr(out_ra_addr), .out_use_rt(out_use_rt), .out_rt_addr(out_rt_addr),
    .out_write_dst(out_write_dst), .out_rw_addr(out_rw_addr),
    .out_prev_rw_addr(out_prev_rw_addr), .out_rs_addr(out_rs_addr),
    .out_prev_rs_addr(out_prev_rs_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    eb_payload_t p;
    bit          ra_ok;
    bit          rt_ok;
  } m_instr_t;

  typedef struct {
    bit          chk;
    bit          ov;
    bit          full;
    logic [63:0] pl;
  } exp_t;

  m_instr_t    mq[$];
  bit          busy[NumDReg];
  bit          known = 1'b0;
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_issued = 0;
  logic [RW:0] rob_ctr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic eb_payload_t dut_payload();
    eb_payload_t p;
    p.rob_addr     = out_rob_addr;
    p.alu_op       = out_alu_op;
    p.immdt        = out_immdt;
    p.ra_addr      = out_ra_addr;
    p.use_rt       = out_use_rt;
    p.rt_addr      = out_rt_addr;
    p.write_dst    = out_write_dst;
    p.rw_addr      = out_rw_addr;
    p.prev_rw_addr = out_prev_rw_addr;
    p.rs_addr      = out_rs_addr;
    p.prev_rs_addr = out_prev_rs_addr;
    return p;
  endfunction

  // Reference: in-order list of waiting instructions plus a busy array.
  task automatic tick();
    exp_t     e;
    m_instr_t ni;
    int       idx;
    bit       acc;
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].ra_ok && mq[i].rt_ok) idx = i;
    e.chk  = known;
    e.ov   = (idx >= 0) && !ex_stall && !flush;
    e.full = (mq.size() == EB);
    e.pl   = '0;
    if (e.ov) e.pl = 64'(mq[idx].p);
    exp_q.push_back(e);
    if (rst) begin
      mq.delete();
      foreach (busy[i]) busy[i] = 1'b0;
      known = 1'b1;
    end else begin
      acc = in_valid && !e.full && !flush;
      ni.p.rob_addr     = in_rob_addr;
      ni.p.alu_op       = in_alu_op;
      ni.p.immdt        = in_immdt;
      ni.p.ra_addr      = in_ra_addr;
      ni.p.use_rt       = in_use_rt;
      ni.p.rt_addr      = in_rt_addr;
      ni.p.write_dst    = in_write_dst;
      ni.p.rw_addr      = in_rw_addr;
      ni.p.prev_rw_addr = in_prev_rw_addr;
      ni.p.rs_addr      = in_rs_addr;
      ni.p.prev_rs_addr = in_prev_rs_addr;
      ni.ra_ok = !busy[in_ra_addr] || (wb_valid && wb_rw_addr == in_ra_addr);
      ni.rt_ok = !in_use_rt || !busy[in_rt_addr] || (wb_valid && wb_rw_addr == in_rt_addr);
      if (e.ov) mq.delete(idx);
      if (wb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].p.ra_addr == wb_rw_addr) mq[i].ra_ok = 1'b1;
          if (mq[i].p.rt_addr == wb_rw_addr) mq[i].rt_ok = 1'b1;
        end
        busy[wb_rw_addr] = 1'b0;
      end
      if (flush) mq.delete();
      else if (acc) mq.push_back(ni);
      if (acc && in_write_dst) busy[in_rw_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; in_valid = 1'b0; wb_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    wb_rw_addr = '0;
  endtask

  task automatic set_instr(input int ra, input bit urt, input int rt, input bit wd, input int rw);
    in_valid        = 1'b1;
    in_rob_addr     = rob_ctr[RW-1:0];
    rob_ctr         = rob_ctr + 1'b1;
    in_alu_op       = alu_op_t'(3'($urandom_range(0, 7)));
    in_immdt        = 16'($urandom);
    in_ra_addr      = DW'(ra);
    in_use_rt       = urt;
    in_rt_addr      = DW'(rt);
    in_write_dst    = wd;
    in_rw_addr      = DW'(rw);
    in_prev_rw_addr = DW'($urandom);
    in_rs_addr      = SW'($urandom);
    in_prev_rs_addr = SW'($urandom);
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      tick();
    end
  endtask

  task automatic wb_tick(input int tag);
    set_idle();
    wb_valid   = 1'b1;
    wb_rw_addr = DW'(tag);
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("full", 64'(full), 64'(e.full));
          check("out_valid", 64'(out_valid), 64'(e.ov));
          if (e.ov && out_valid) begin
            n_issued++;
            check("issue_payload", 64'(dut_payload()), e.pl);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int tags[$];
    set_idle();
    set_instr(0, 1'b0, 0, 1'b0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();

    // Eight independent instructions, one per cycle.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_instr(i, 1'b1, 7 - i, 1'b1, 16 + i);
      tick();
    end
    idle_ticks(2);
    for (int i = 0; i < 8; i++) wb_tick(16 + i);

    // Dependent consumer woken by a later writeback.
    set_idle(); set_instr(1, 1'b0, 0, 1'b1, 5); tick();
    set_idle(); set_instr(5, 1'b0, 0, 1'b0, 0); tick();
    idle_ticks(3);
    wb_tick(5);
    idle_ticks(2);

    // Consumer accepted in the same cycle as its producer's writeback.
    set_idle(); set_instr(1, 1'b0, 0, 1'b1, 5); tick();
    idle_ticks(2);
    set_idle(); set_instr(5, 1'b1, 2, 1'b0, 0); wb_valid = 1'b1; wb_rw_addr = 5; tick();
    idle_ticks(2);

    // Fill under stall, ninth refused, then drain.
    for (int i = 0; i < 9; i++) begin
      set_idle(); ex_stall = 1'b1; set_instr(i, 1'b1, i + 1, 1'b0, 0); tick();
    end
    idle_ticks(10);

    // Blocked oldest entry bypassed by a younger ready one.
    set_idle(); set_instr(2, 1'b0, 0, 1'b1, 6); tick();
    set_idle(); set_instr(6, 1'b0, 0, 1'b0, 0); tick();
    set_idle(); set_instr(3, 1'b1, 4, 1'b0, 0); tick();
    idle_ticks(3);
    wb_tick(6);
    idle_ticks(2);

    // Flush with five blocked entries, then reset alongside an incoming instruction.
    set_idle(); set_instr(2, 1'b0, 0, 1'b1, 7); tick();
    for (int i = 0; i < 5; i++) begin
      set_idle(); set_instr(7, 1'b0, 0, 1'b0, 0); tick();
    end
    idle_ticks(1);
    set_idle(); flush = 1'b1; tick();
    idle_ticks(2);
    wb_tick(7);
    set_idle(); set_instr(1, 1'b0, 0, 1'b0, 0); rst = 1'b1; tick();
    idle_ticks(3);

    for (int c = 0; c < 800; c++) begin
      set_idle();
      if ($urandom_range(0, 99) < 60) begin
        set_instr($urandom_range(0, NumDReg - 1), 1'($urandom), $urandom_range(0, NumDReg - 1),
                  1'($urandom), $urandom_range(0, NumDReg - 1));
      end
      if ($urandom_range(0, 99) < 45) begin
        tags.delete();
        foreach (busy[i]) if (busy[i]) tags.push_back(i);
        wb_valid = 1'b1;
        if (tags.size() > 0 && $urandom_range(0, 99) < 80)
          wb_rw_addr = DW'(tags[$urandom_range(0, tags.size() - 1)]);
        else
          wb_rw_addr = DW'($urandom);
      end
      ex_stall = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 2);
      rst      = ($urandom_range(0, 199) < 1);
      tick();
    end
    idle_ticks(2);
    @(negedge clk);
    #1;
    check("issued_some", 64'(n_issued > 50), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
